image_rom_arbiter: RTL and testbench

IMAGE_ROM_ARBITER -- requirements
Module: image_rom_arbiter

---
 rtl/picture_pkg.sv | 37 +++
 rtl/rom_tag_pipe.sv | 31 +++
 rtl/image_rom_arbiter.sv | 137 +++++++++++++
 tb/tb_image_rom_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/picture_pkg.sv
// Shared widths, slot tags and aux FSM states for the image ROM arbiter.
package picture_pkg;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 6;

    typedef enum logic [1:0] {
        TAG_NONE    = 2'd0,
        TAG_VID     = 2'd1,
        TAG_AUX     = 2'd2,
        TAG_AUX_OOB = 2'd3
    } tag_e;

    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_PEND   = 2'd1,
        A_FLIGHT = 2'd2
    } aux_state_e;

    // A slot can carry a video read and an out-of-range aux completion at
    // once, because an out-of-range aux grant never touches the ROM.
    typedef struct packed {
        tag_e vid_tag;
        logic vid_oob;
        tag_e aux_tag;
    } slot_t;

    localparam int SLOT_W = $bits(slot_t);

    localparam slot_t SLOT_IDLE = '{vid_tag: TAG_NONE, vid_oob: 1'b0, aux_tag: TAG_NONE};

    function automatic logic in_image(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W:0]   words);
        return {1'b0, addr} < words;
    endfunction

endpackage

// File: rtl/rom_tag_pipe.sv
// Shift register that carries each ROM slot's tag alongside the ROM read,
// so the tail lines up with the returned rom_data.
module rom_tag_pipe
    import picture_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SLOT_W-1:0] slot_in,
    output logic [SLOT_W-1:0] slot_out
);

    logic [SLOT_W-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= SLOT_IDLE;
            end
        end else begin
            stage[0] <= slot_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign slot_out = stage[DEPTH-1];

endmodule

// File: rtl/image_rom_arbiter.sv
// Shares one image ROM between a never-stalled video scan port and a
// secondary requester; video always wins, aux waits and reports starvation.
module image_rom_arbiter
    import picture_pkg::*;
#(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int ROM_LAT    = 1,
    parameter int STARVE_LIM = 1024
) (
    input  logic              pixel_clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_gnt,
    output logic              aux_valid,
    output logic [DATA_W-1:0] aux_data,
    output logic              aux_oob,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              starve,
    output logic [1:0]        aux_state
);

    localparam int              L          = 1 + ROM_LAT;
    localparam logic [ADDR_W:0] IMG_WORDS  = (ADDR_W + 1)'(WIDTH * HEIGHT);
    localparam logic [16:0]     STARVE_THR = 17'(STARVE_LIM);
    localparam logic [15:0]     WAIT_MAX   = 16'hFFFF;

    aux_state_e        state_q;
    aux_state_e        state_d;
    logic              aux_issue;
    logic              vid_ok;
    logic              aux_ok;
    logic [15:0]       wait_cnt;
    logic [15:0]       wait_cnt_d;
    logic [ADDR_W-1:0] rom_addr_d;
    slot_t             slot_in;
    slot_t             slot_tail;
    logic [SLOT_W-1:0] tail_bits;

    assign vid_ok = in_image(vid_addr, IMG_WORDS);
    assign aux_ok = in_image(aux_addr, IMG_WORDS);

    // Aux FSM; an out-of-range address is granted even against video
    // because it needs no ROM slot.
    always_comb begin
        state_d   = state_q;
        aux_gnt   = 1'b0;
        aux_issue = 1'b0;
        case (state_q)
            A_IDLE: begin
                if (aux_req) begin
                    state_d = A_PEND;
                end
            end
            A_PEND: begin
                if (!aux_ok) begin
                    aux_gnt = 1'b1;
                    state_d = A_FLIGHT;
                end else if (!vid_req) begin
                    aux_gnt   = 1'b1;
                    aux_issue = 1'b1;
                    state_d   = A_FLIGHT;
                end
            end
            A_FLIGHT: begin
                if (aux_valid) begin
                    state_d = A_IDLE;
                end
            end
            default: state_d = A_IDLE;
        endcase
    end

    always_comb begin
        slot_in    = SLOT_IDLE;
        rom_addr_d = rom_addr;
        if (vid_req) begin
            slot_in.vid_tag = TAG_VID;
            slot_in.vid_oob = !vid_ok;
            rom_addr_d      = vid_addr;
        end else if (aux_issue) begin
            rom_addr_d = aux_addr;
        end
        if (aux_gnt) begin
            slot_in.aux_tag = aux_issue ? TAG_AUX : TAG_AUX_OOB;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt;
        if (aux_gnt) begin
            wait_cnt_d = '0;
        end else if (state_q == A_PEND && wait_cnt != WAIT_MAX) begin
            wait_cnt_d = wait_cnt + 16'd1;
        end
    end

    rom_tag_pipe #(
        .DEPTH (L)
    ) u_tag_pipe (
        .clk      (pixel_clk),
        .rst_n    (reset_n),
        .slot_in  (slot_in),
        .slot_out (tail_bits)
    );

    assign slot_tail = slot_t'(tail_bits);

    assign vid_valid = (slot_tail.vid_tag == TAG_VID);
    assign vid_data  = (vid_valid && !slot_tail.vid_oob) ? rom_data : '0;
    assign aux_valid = (slot_tail.aux_tag != TAG_NONE);
    assign aux_data  = (slot_tail.aux_tag == TAG_AUX) ? rom_data : '0;
    assign aux_oob   = (slot_tail.aux_tag == TAG_AUX_OOB);
    assign aux_state = state_q;

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= A_IDLE;
            rom_addr <= '0;
            wait_cnt <= '0;
            starve   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rom_addr <= rom_addr_d;
            wait_cnt <= wait_cnt_d;
            // Tracks the counter register so starve drops right after a grant.
            starve   <= ({1'b0, wait_cnt_d} >= STARVE_THR);
        end
    end

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Randomized bench for image_rom_arbiter against a cycle-numbered reference
// model of read completions, aux grants and starvation.
module tb_image_rom_arbiter;

    localparam int IMG_WORDS  = 320 * 240;
    localparam int STARVE_LIM = 1024;
    localparam int LAT        = 2;

    logic        pixel_clk = 1'b0;
    logic        reset_n   = 1'b0;
    logic        vid_req   = 1'b0;
    logic [16:0] vid_addr  = '0;
    logic        vid_valid;
    logic [5:0]  vid_data;
    logic        aux_req   = 1'b0;
    logic [16:0] aux_addr  = '0;
    logic        aux_gnt;
    logic        aux_valid;
    logic [5:0]  aux_data;
    logic        aux_oob;
    logic [16:0] rom_addr;
    logic [5:0]  rom_data  = '0;
    logic        starve;
    logic [1:0]  aux_state;

    image_rom_arbiter #(
        .WIDTH      (320),
        .HEIGHT     (240),
        .ROM_LAT    (1),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .pixel_clk (pixel_clk),
        .reset_n   (reset_n),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_valid (vid_valid),
        .vid_data  (vid_data),
        .aux_req   (aux_req),
        .aux_addr  (aux_addr),
        .aux_gnt   (aux_gnt),
        .aux_valid (aux_valid),
        .aux_data  (aux_data),
        .aux_oob   (aux_oob),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .starve    (starve),
        .aux_state (aux_state)
    );

    // Clock and one-cycle-latency image ROM.
    always #5 pixel_clk = ~pixel_clk;

    function automatic logic [5:0] rom_fn(input logic [16:0] a);
        logic [31:0] m;
        m = 32'(a) * 32'd13;
        return m[5:0] ^ a[11:6];
    endfunction

    always @(posedge pixel_clk) rom_data <= rom_fn(rom_addr);

    // Scoreboard state.
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [5:0]  exp_q[$];
    int          due_q[$];
    logic        aux_wait;
    int          aux_wait_from;
    logic        aux_out;
    int          aux_due;
    logic [5:0]  aux_exp_data;
    logic        aux_exp_oob;
    int          aux_free_from;
    int          waited;
    logic [16:0] exp_rom;
    logic        gnt_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (model cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        due_q.delete();
        aux_wait      = 1'b0;
        aux_wait_from = 0;
        aux_out       = 1'b0;
        aux_due       = 0;
        aux_exp_data  = '0;
        aux_exp_oob   = 1'b0;
        aux_free_from = cyc;
        waited        = 0;
        exp_rom       = '0;
    endtask

    // One cycle of the reference model, evaluated with this cycle's inputs applied.
    task automatic model_cycle();
        logic exp_vv;
        logic exp_g;
        logic pending;
        logic aux_in;
        exp_vv = (due_q.size() > 0) && (due_q[0] == cyc);
        check("vid_valid", 32'(vid_valid), 32'(exp_vv));
        if (exp_vv) begin
            check("vid_data", 32'(vid_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end
        check("aux_valid", 32'(aux_valid), 32'(aux_out && aux_due == cyc));
        if (aux_out && aux_due == cyc) begin
            check("aux_data", 32'(aux_data), 32'(aux_exp_data));
            check("aux_oob", 32'(aux_oob), 32'(aux_exp_oob));
            aux_out       = 1'b0;
            aux_free_from = cyc + 1;
        end
        check("starve", 32'(starve), 32'(waited >= STARVE_LIM));
        check("rom_addr", 32'(rom_addr), 32'(exp_rom));

        aux_in  = int'(aux_addr) < IMG_WORDS;
        pending = aux_wait && cyc >= aux_wait_from;
        exp_g   = pending && (!aux_in || !vid_req);
        check("aux_gnt", 32'(aux_gnt), 32'(exp_g));
        if (exp_g) begin
            aux_out      = 1'b1;
            aux_due      = cyc + LAT;
            aux_exp_data = aux_in ? rom_fn(aux_addr) : 6'd0;
            aux_exp_oob  = !aux_in;
            aux_wait     = 1'b0;
            waited       = 0;
        end else if (pending) begin
            if (waited < 65535) waited++;
        end
        if (!aux_wait && !aux_out && cyc >= aux_free_from && aux_req) begin
            aux_wait      = 1'b1;
            aux_wait_from = cyc + 1;
        end

        if (vid_req) begin
            exp_q.push_back((int'(vid_addr) < IMG_WORDS) ? rom_fn(vid_addr) : 6'd0);
            due_q.push_back(cyc + LAT);
            exp_rom = vid_addr;
        end else if (exp_g && aux_in) begin
            exp_rom = aux_addr;
        end
        cyc++;
    endtask

    // Driver: aux_req is held with a stable address until a grant is seen.
    task automatic run_cycle(input logic v_req, input logic [16:0] v_addr,
                             input logic a_want, input logic [16:0] a_addr);
        @(negedge pixel_clk);
        if (aux_req && gnt_seen) aux_req = 1'b0;
        if (!aux_req && a_want) begin
            aux_req  = 1'b1;
            aux_addr = a_addr;
        end
        vid_req  = v_req;
        vid_addr = v_addr;
        #1;
        gnt_seen = aux_gnt;
        model_cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vid_valid"}, 32'(vid_valid), 32'd0);
        check({tag, "_vid_data"}, 32'(vid_data), 32'd0);
        check({tag, "_aux_gnt"}, 32'(aux_gnt), 32'd0);
        check({tag, "_aux_valid"}, 32'(aux_valid), 32'd0);
        check({tag, "_aux_data"}, 32'(aux_data), 32'd0);
        check({tag, "_aux_oob"}, 32'(aux_oob), 32'd0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_starve"}, 32'(starve), 32'd0);
        check({tag, "_aux_state"}, 32'(aux_state), 32'd0);
    endtask

    function automatic logic [16:0] rand_addr(input int oob_one_in);
        if ($urandom_range(0, oob_one_in - 1) == 0) return 17'($urandom_range(IMG_WORDS, 131071));
        return 17'($urandom_range(0, IMG_WORDS - 1));
    endfunction

    initial begin
        // Power-on reset.
        #3;
        check_reset_outputs("por");
        model_reset();
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        reset_n = 1'b1;

        // Full video line of 320 back-to-back reads.
        for (int i = 0; i < 320; i++) run_cycle(1'b1, 17'(i), 1'b0, '0);
        for (int i = 0; i < 4; i++) run_cycle(1'b0, '0, 1'b0, '0);

        // Aux read during blanking.
        run_cycle(1'b0, '0, 1'b1, 17'd100);
        for (int i = 0; i < 5; i++) run_cycle(1'b0, '0, 1'b0, '0);

        // Aux starved by continuous video, then released by one blank cycle.
        for (int i = 0; i < 1500; i++) run_cycle(1'b1, rand_addr(64), i == 0, 17'd5000);
        for (int i = 0; i < 5; i++) run_cycle(1'b0, '0, 1'b0, '0);

        // Out-of-range aux granted straight through a video stream.
        run_cycle(1'b1, 17'd10, 1'b1, 17'(IMG_WORDS));
        for (int i = 0; i < 6; i++) run_cycle(1'b1, 17'(11 + i), 1'b0, '0);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, '0, 1'b0, '0);

        // Randomized mix including out-of-range addresses on both ports.
        for (int i = 0; i < 3000; i++) begin
            run_cycle($urandom_range(0, 3) != 0, rand_addr(16),
                      $urandom_range(0, 5) == 0, rand_addr(4));
        end
        for (int i = 0; i < 4; i++) run_cycle(1'b0, '0, 1'b0, '0);

        // Reset with one aux and one video read in flight.
        run_cycle(1'b0, '0, 1'b1, 17'd200);
        run_cycle(1'b0, '0, 1'b0, '0);
        run_cycle(1'b1, 17'd50, 1'b0, '0);
        @(negedge pixel_clk);
        vid_req = 1'b0;
        aux_req = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        reset_n  = 1'b1;
        gnt_seen = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) run_cycle(1'b0, '0, 1'b0, '0);
        check("post_rst_aux_state", 32'(aux_state), 32'd0);
        for (int i = 0; i < 8; i++) run_cycle(1'b1, 17'(300 + i), 1'b0, '0);
        for (int i = 0; i < 4; i++) run_cycle(1'b0, '0, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
